mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit beside the execute-stage ALU.
// A radix-2 shift-add multiplier and a restoring divider share one 64-bit
// working register; each iterative operation takes 32 cycles. Division by
// zero and signed overflow complete in one cycle.
//
// Ports:
//   clk_i, rst_i      clock; synchronous active-high reset
//   valid_i, ready_o  request handshake (ready_o high only in IDLE)
//   opcode_i          core_package::md_op_e encoding
//   operand_A_i/B_i   rs1 / rs2, sampled only on acceptance
//   kill_i            abort the in-flight operation, or block acceptance
//   valid_o, ready_i  response handshake; result held until ready_i
//   result_o          32-bit result

package core_package;
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;
endpackage

module mul_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  opcode_i,
    input  logic [31:0] operand_A_i,
    input  logic [31:0] operand_B_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);
    import core_package::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e      state_q,  state_d;
    md_op_e      op_q,     op_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [63:0] work_q,   work_d;
    logic [31:0] b_q,      b_d;
    logic        neg_q,    neg_d;
    logic [31:0] result_q, result_d;

    md_op_e      op_in;
    logic        is_div_in;
    logic        a_neg_in;
    logic        b_neg_in;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] mul_prod;
    logic [32:0] rem_shift;
    logic [31:0] rem_diff;
    logic [63:0] div_step;
    logic [31:0] div_raw;

    always_comb begin
        op_in     = md_op_e'(opcode_i);
        is_div_in = opcode_i[2];
        // MD_MUL is treated as unsigned: its low half does not depend on signedness.
        a_neg_in  = operand_A_i[31] &&
                    (op_in == MD_MULH || op_in == MD_MULHSU ||
                     op_in == MD_DIV  || op_in == MD_REM);
        b_neg_in  = operand_B_i[31] &&
                    (op_in == MD_MULH || op_in == MD_DIV || op_in == MD_REM);
        a_mag     = a_neg_in ? -operand_A_i : operand_A_i;
        b_mag     = b_neg_in ? -operand_B_i : operand_B_i;
        div_zero  = is_div_in && (operand_B_i == '0);
        div_ovf   = (op_in == MD_DIV || op_in == MD_REM) &&
                    (operand_A_i == 32'h8000_0000) && (operand_B_i == '1);

        // Multiply step: work = {partial product, remaining multiplier bits}.
        mul_sum  = work_q[0] ? ({1'b0, work_q[63:32]} + {1'b0, b_q})
                             : {1'b0, work_q[63:32]};
        mul_step = {mul_sum, work_q[31:1]};
        mul_prod = neg_q ? -mul_step : mul_step;

        // Restoring divide step: work = {partial remainder, dividend/quotient}.
        // A successful trial subtraction always fits back into 32 bits.
        rem_shift = work_q[63:31];
        rem_diff  = rem_shift[31:0] - b_q;
        div_step  = (rem_shift >= {1'b0, b_q}) ? {rem_diff, work_q[30:0], 1'b1}
                                                : {work_q[62:0], 1'b0};
        div_raw   = op_q[1] ? div_step[63:32] : div_step[31:0];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        b_d      = b_q;
        neg_d    = neg_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid_i && !kill_i) begin
                    op_d   = op_in;
                    b_d    = b_mag;
                    cnt_d  = 5'd31;
                    work_d = {32'h0, a_mag};
                    // REM follows the dividend sign; everything else the sign product.
                    neg_d  = (is_div_in && opcode_i[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
                    if (div_zero) begin
                        result_d = opcode_i[1] ? operand_A_i : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = opcode_i[1] ? 32'h0 : 32'h8000_0000;
                        state_d  = S_DONE;
                    end else if (is_div_in) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = mul_step;
                    if (cnt_q == 5'd0) begin
                        result_d = (op_q == MD_MUL) ? mul_prod[31:0] : mul_prod[63:32];
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_DIV: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = div_step;
                    if (cnt_q == 5'd0) begin
                        result_d = neg_q ? -div_raw : div_raw;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (kill_i || ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            work_q   <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
// Latency is counted in clock edges after the acceptance edge, sampled 1ns
// after each rising edge: iterative ops show valid_o after 32 edges, fast-path
// ops immediately after the acceptance edge.

module tb_mul_div_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  opcode_i;
    logic [31:0] operand_A_i;
    logic [31:0] operand_B_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    mul_div_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .opcode_i    (opcode_i),
        .operand_A_i (operand_A_i),
        .operand_B_i (operand_B_i),
        .kill_i      (kill_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    // Presents one request for one edge, scrambles the operands afterwards,
    // then waits (bounded) for valid_o. lat = edges after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic rdy_seen);
        opcode_i    = op;
        operand_A_i = a;
        operand_B_i = b;
        valid_i     = 1'b1;
        @(posedge clk_i); #1;
        valid_i     = 1'b0;
        opcode_i    = 3'd3;
        operand_A_i = 32'hDEAD_BEEF;
        operand_B_i = 32'h1234_5678;
        lat         = 0;
        rdy_seen    = ready_o;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
            if (ready_o) rdy_seen = 1'b1;
        end
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h, expected 1 0 00000000",
                     ready_o, valid_o, result_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{OP_MUL, OP_MULHU, OP_MULHSU, OP_MULH};
        logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd3};
        logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat;
        logic rdy;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], lat, rdy);
            tests_run++;
            if (result_o !== exp[i] || lat != 32 || rdy !== 1'b0) begin
                tests_failed++;
                $display("FAIL mul_%0d: result=%h lat=%0d ready_seen=%b, expected %h lat=32 ready_seen=0",
                         i, result_o, lat, rdy, exp[i]);
            end
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [5] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIVU};
        logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'hFFFF_FFFF};
        logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd1};
        logic [31:0] exp [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF};
        int lat;
        logic rdy;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], lat, rdy);
            tests_run++;
            if (result_o !== exp[i] || lat != 32 || rdy !== 1'b0) begin
                tests_failed++;
                $display("FAIL div_%0d: result=%h lat=%0d ready_seen=%b, expected %h lat=32 ready_seen=0",
                         i, result_o, lat, rdy, exp[i]);
            end
            consume();
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  ops [5] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_REMU};
        logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hCAFE_0001};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hCAFE_0001};
        int lat;
        logic rdy;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], lat, rdy);
            tests_run++;
            if (result_o !== exp[i] || lat != 0 || ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL fast_%0d: result=%h lat=%0d ready=%b, expected %h lat=0 ready=0",
                         i, result_o, lat, ready_o, exp[i]);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic rdy;
        int bad;
        issue(OP_DIVU, 32'd100, 32'd7, lat, rdy);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            if (valid_o !== 1'b1 || result_o !== 32'd14 || ready_o !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: %0d unstable cycles (last valid=%b result=%h ready=%b), expected 0",
                     bad, valid_o, result_o, ready_o);
        end
        consume();
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_to_idle: ready=%b valid=%b, expected 1 0", ready_o, valid_o);
        end
        issue(OP_REMU, 32'd100, 32'd7, lat, rdy);
        tests_run++;
        if (result_o !== 32'd2 || lat != 32) begin
            tests_failed++;
            $display("FAIL back_to_back: result=%h lat=%0d, expected 00000002 lat=32", result_o, lat);
        end
        consume();
    endtask

    task automatic test_kill();
        int lat;
        logic rdy;
        opcode_i    = OP_DIV;
        operand_A_i = 32'd1000;
        operand_B_i = 32'd3;
        valid_i     = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (14) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_iter: ready=%b valid=%b, expected 1 0", ready_o, valid_o);
        end
        // A request presented with kill_i high must be ignored.
        opcode_i = OP_DIVU; operand_A_i = 32'd9; operand_B_i = 32'd0;
        valid_i  = 1'b1; kill_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_idle_block: ready=%b valid=%b, expected 1 0", ready_o, valid_o);
        end
        issue(OP_MUL, 32'd3, 32'd4, lat, rdy);
        tests_run++;
        if (result_o !== 32'd12 || lat != 32) begin
            tests_failed++;
            $display("FAIL after_kill_mul: result=%h lat=%0d, expected 0000000c lat=32", result_o, lat);
        end
        // Kill in DONE discards the result.
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_done: ready=%b valid=%b, expected 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic rdy;
        opcode_i = OP_MUL; operand_A_i = 32'd7; operand_B_i = 32'd9;
        valid_i  = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        opcode_i = OP_MUL; operand_A_i = 32'd3; operand_B_i = 32'd4;
        valid_i  = 1'b1;
        @(posedge clk_i); #1;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_mul: ready=%b valid=%b result=%h, expected 1 0 00000000",
                     ready_o, valid_o, result_o);
        end
        @(posedge clk_i); #1;
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_blocks_accept: ready=%b, expected 1", ready_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_after_reset: ready=%b, expected 0", ready_o);
        end
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        tests_run++;
        if (result_o !== 32'd12 || lat != 32) begin
            tests_failed++;
            $display("FAIL post_reset_mul: result=%h lat=%0d, expected 0000000c lat=32", result_o, lat);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_in_done: ready=%b valid=%b result=%h, expected 1 0 00000000",
                     ready_o, valid_o, result_o);
        end
        issue(OP_DIVU, 32'd5, 32'd0, lat, rdy);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_in_fast_done: ready=%b valid=%b result=%h, expected 1 0 00000000",
                     ready_o, valid_o, result_o);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        opcode_i    = 3'd0;
        operand_A_i = '0;
        operand_B_i = '0;
        kill_i      = 1'b0;
        ready_i     = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
